// File: rtl/lsu.sv
// Load/store unit: turns an ALU effective address into a single data-memory
// access with valid/ready request, valid response, lane extraction and error flags.
module lsu #(
  parameter int TIMEOUT    = 256,
  parameter bit TIMEOUT_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic        done,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        bus_err,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_rdata
);
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  typedef struct packed {
    logic       we;
    logic [2:0] funct3;
    logic [1:0] ofs;
    logic       mis;
  } req_t;

  state_t        state, state_nxt;
  req_t          rq;
  logic          err_q;
  logic [CW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic          illegal, unaligned, bad;
  logic [3:0]    strb;
  logic [31:0]   wd;
  logic [7:0]    rb;
  logic [15:0]   rh;
  logic [31:0]   ext;

  // request decode straight off the inputs, used only in the IDLE latch cycle
  always_comb begin
    illegal   = req_we ? (req_funct3 > 3'b010)
                       : (req_funct3 == 3'b011 || req_funct3[2:1] == 2'b11);
    unaligned = (req_funct3[1:0] == 2'b01 && addr[0]) ||
                (req_funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
    bad       = illegal | unaligned;
    strb      = 4'b0000;
    wd        = 32'h0;
    if (req_we) begin
      case (req_funct3[1:0])
        2'b00:   begin strb = 4'b0001 << addr[1:0]; wd = {4{store_data[7:0]}};  end
        2'b01:   begin strb = 4'b0011 << addr[1:0]; wd = {2{store_data[15:0]}}; end
        default: begin strb = 4'b1111;              wd = store_data;            end
      endcase
    end
  end

  // load lane extraction against the latched offset/funct3
  always_comb begin
    case (rq.ofs)
      2'd0:    rb = mem_rsp_rdata[7:0];
      2'd1:    rb = mem_rsp_rdata[15:8];
      2'd2:    rb = mem_rsp_rdata[23:16];
      default: rb = mem_rsp_rdata[31:24];
    endcase
    rh = rq.ofs[1] ? mem_rsp_rdata[31:16] : mem_rsp_rdata[15:0];
    case (rq.funct3)
      3'b000:  ext = {{24{rb[7]}}, rb};
      3'b001:  ext = {{16{rh[15]}}, rh};
      3'b100:  ext = {24'h0, rb};
      3'b101:  ext = {16'h0, rh};
      default: ext = mem_rsp_rdata;
    endcase
  end

  // expiry fires in the TIMEOUT-th cycle spent in REQ+RESP
  assign tmo_hit = TIMEOUT_EN && (tmo_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // a completing handshake wins over a simultaneous timeout
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req_valid) state_nxt = bad ? DONE : REQ;
      REQ:  if (mem_req_ready) state_nxt = rq.we ? DONE : RESP;
            else if (tmo_hit)  state_nxt = DONE;
      RESP: if (mem_rsp_valid || tmo_hit) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    done          = (state == DONE);
    misaligned    = done & rq.mis;
    bus_err       = done & err_q;
    mem_req_valid = (state == REQ);
    stall         = req_valid & ~done;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rq        <= '0;
      err_q     <= 1'b0;
      tmo_cnt   <= '0;
      load_data <= 32'h0;
      mem_addr  <= 32'h0;
      mem_we    <= 1'b0;
      mem_wstrb <= 4'h0;
      mem_wdata <= 32'h0;
    end else begin
      if (state == REQ || state == RESP) begin
        if (tmo_cnt != CW'(TIMEOUT)) tmo_cnt <= tmo_cnt + CW'(1);
      end else begin
        tmo_cnt <= '0;
      end
      case (state)
        IDLE: if (req_valid) begin
          rq        <= '{we: req_we, funct3: req_funct3, ofs: addr[1:0], mis: bad};
          err_q     <= 1'b0;
          load_data <= 32'h0;
          mem_addr  <= {addr[31:2], 2'b00};
          mem_we    <= req_we;
          mem_wstrb <= strb;
          mem_wdata <= wd;
        end
        REQ:  if (!mem_req_ready && tmo_hit) err_q <= 1'b1;
        RESP: if (mem_rsp_valid) load_data <= ext;
              else if (tmo_hit)  err_q <= 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu.sv
// Scoreboarded bench for lsu: a cycle-stepped bus responder drives each access
// and expected completions are queued for a done-pulse monitor.
module tb_lsu;
  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] addr, store_data;
  logic        stall, done, misaligned, bus_err;
  logic [31:0] load_data;
  logic        mem_req_valid, mem_req_ready, mem_we, mem_rsp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rsp_rdata;
  logic [3:0]  mem_wstrb;

  int ncmp = 0;
  int nerr = 0;

  typedef struct {
    logic [31:0] ld;
    logic        mis;
    logic        err;
  } exp_t;
  exp_t sbq[$];

  lsu #(.TIMEOUT(8), .TIMEOUT_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we),
    .req_funct3(req_funct3), .addr(addr), .store_data(store_data),
    .stall(stall), .done(done), .load_data(load_data),
    .misaligned(misaligned), .bus_err(bus_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_rdata(mem_rsp_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!rst && done) begin
      if (sbq.size() == 0) begin
        chk("spurious_done", 32'(done), 32'd0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("load_data",  load_data,        e.ld);
        chk("misaligned", 32'(misaligned),  32'(e.mis));
        chk("bus_err",    32'(bus_err),     32'(e.err));
      end
    end
  end

  // Starts at the negedge of the DONE (or idle) cycle; cycle 0 is the IDLE
  // cycle in which req_valid is presented.
  task automatic access(input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] rd, input int rdy_dly,
                        input int rsp_dly, input bit rsp_en,
                        input logic [31:0] exp_ld, input bit exp_mis,
                        input bit exp_err, input logic [3:0] exp_strb,
                        input int exp_lat);
    int  cyc, rdy_wait, rsp_wait;
    bit  seen_req, accepted;
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    e.ld = exp_ld; e.mis = exp_mis; e.err = exp_err;
    sbq.push_back(e);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; addr = a; store_data = d;
    mem_rsp_rdata = rd;
    #1 chk("stall_idle", 32'(stall), 32'd1);
    cyc = 0; rdy_wait = 0; rsp_wait = 0; seen_req = 0; accepted = 0;
    forever begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      mem_req_ready = 1'b0;
      mem_rsp_valid = 1'b0;
      if (done) begin
        chk("latency",        32'(cyc),            32'(exp_lat));
        chk("stall_done",     32'(stall),          32'd0);
        chk("req_seen",       32'(seen_req),       32'(!exp_mis));
        chk("req_valid_done", 32'(mem_req_valid),  32'd0);
        req_valid = 1'b0;
        break;
      end
      if (cyc > 40) begin
        chk("no_done", 32'(done), 32'd1);
        req_valid = 1'b0;
        void'(sbq.pop_back());
        break;
      end
      if (stall !== 1'b1) chk("stall_busy", 32'(stall), 32'd1);
      if (mem_req_valid) begin
        seen_req = 1;
        if (mem_addr  !== {a[31:2], 2'b00}) chk("mem_addr",  mem_addr,         {a[31:2], 2'b00});
        if (mem_we    !== we)               chk("mem_we",    32'(mem_we),      32'(we));
        if (mem_wstrb !== exp_strb)         chk("mem_wstrb", 32'(mem_wstrb),   32'(exp_strb));
        if (we && mem_wdata !== exp_wd(f3, d)) chk("mem_wdata", mem_wdata, exp_wd(f3, d));
        mem_req_ready = (rdy_wait >= rdy_dly);
        rdy_wait++;
        if (mem_req_ready) accepted = 1;
      end else if (accepted && !we) begin
        mem_rsp_valid = rsp_en && (rsp_wait >= rsp_dly);
        rsp_wait++;
      end
    end
    if (seen_req) begin
      chk("acc_addr",  mem_addr,          {a[31:2], 2'b00});
      chk("acc_strb",  32'(mem_wstrb),    32'(exp_strb));
    end
  endtask

  function automatic logic [31:0] exp_wd(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   return {d[7:0], d[7:0], d[7:0], d[7:0]};
      2'b01:   return {d[15:0], d[15:0]};
      default: return d;
    endcase
  endfunction

  initial begin
    rst = 1'b1; req_valid = 0; req_we = 0; req_funct3 = 0; addr = 0;
    store_data = 0; mem_req_ready = 0; mem_rsp_valid = 0; mem_rsp_rdata = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_done",      32'(done),          32'd0);
    chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_mem_addr",  mem_addr,           32'd0);
    chk("rst_wstrb",     32'(mem_wstrb),     32'd0);
    chk("rst_load_data", load_data,          32'd0);
    chk("rst_stall",     32'(stall),         32'd0);
    rst = 1'b0;

    //     we  f3      addr          data          rdata         rdy rsp en  exp_ld        mis err strb     lat
    access(1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,        0, 0, 0, 32'h0,        0, 0, 4'b1111, 2);
    access(0, 3'b000, 32'h103, 32'h0,        32'h80FFFF00, 0, 0, 1, 32'hFFFFFF80, 0, 0, 4'b0000, 3);
    access(0, 3'b100, 32'h103, 32'h0,        32'h80FFFF00, 0, 0, 1, 32'h00000080, 0, 0, 4'b0000, 3);
    access(0, 3'b001, 32'h102, 32'h0,        32'h1234ABCD, 0, 0, 1, 32'h00001234, 0, 0, 4'b0000, 3);
    access(0, 3'b001, 32'h100, 32'h0,        32'h1234ABCD, 0, 0, 1, 32'hFFFFABCD, 0, 0, 4'b0000, 3);
    access(0, 3'b101, 32'h100, 32'h0,        32'h1234ABCD, 0, 0, 1, 32'h0000ABCD, 0, 0, 4'b0000, 3);
    access(0, 3'b010, 32'h104, 32'h0,        32'h1234ABCD, 0, 0, 1, 32'h1234ABCD, 0, 0, 4'b0000, 3);
    access(1, 3'b001, 32'h102, 32'h00005678, 32'h0,        0, 0, 0, 32'h0,        0, 0, 4'b1100, 2);
    access(1, 3'b000, 32'h101, 32'h000000A5, 32'h0,        0, 0, 0, 32'h0,        0, 0, 4'b0010, 2);
    access(0, 3'b000, 32'h102, 32'h0,        32'h00C30000, 1, 2, 1, 32'hFFFFFFC3, 0, 0, 4'b0000, 6);
    // misaligned / illegal go straight from IDLE to DONE
    access(0, 3'b010, 32'h101, 32'h0,        32'h0,        0, 0, 1, 32'h0,        1, 0, 4'b0000, 1);
    access(0, 3'b011, 32'h100, 32'h0,        32'h0,        0, 0, 1, 32'h0,        1, 0, 4'b0000, 1);
    access(1, 3'b001, 32'h103, 32'h1111,     32'h0,        0, 0, 0, 32'h0,        1, 0, 4'b0000, 1);
    access(1, 3'b100, 32'h100, 32'h1111,     32'h0,        0, 0, 0, 32'h0,        1, 0, 4'b0000, 1);
    // timeouts: 8 cycles in REQ+RESP, then DONE with bus_err
    access(0, 3'b010, 32'h200, 32'h0,        32'h55555555, 3, 0, 0, 32'h0,        0, 1, 4'b0000, 9);
    access(1, 3'b010, 32'h300, 32'h12345678, 32'h0,       99, 0, 0, 32'h0,        0, 1, 4'b1111, 9);

    // abort a load in RESP with rst; a late response must not complete it
    @(posedge clk); @(negedge clk);
    req_valid = 1; req_we = 0; req_funct3 = 3'b010; addr = 32'h400;
    @(posedge clk); @(negedge clk);
    chk("abort_in_req", 32'(mem_req_valid), 32'd1);
    mem_req_ready = 1;
    @(posedge clk); @(negedge clk);
    mem_req_ready = 0;
    chk("abort_in_resp", 32'(mem_req_valid | done), 32'd0);
    rst = 1;
    @(posedge clk); @(negedge clk);
    rst = 0; req_valid = 0;
    chk("abort_req_valid", 32'(mem_req_valid), 32'd0);
    chk("abort_done",      32'(done),          32'd0);
    chk("abort_mem_addr",  mem_addr,           32'd0);
    mem_rsp_valid = 1; mem_rsp_rdata = 32'hCAFEF00D;
    @(posedge clk); @(negedge clk);
    mem_rsp_valid = 0;
    repeat (3) begin
      @(posedge clk); @(negedge clk);
      chk("late_rsp_done", 32'(done | mem_req_valid), 32'd0);
    end

    access(1, 3'b010, 32'h500, 32'hA5A5F00F, 32'h0,        0, 0, 0, 32'h0,        0, 0, 4'b1111, 2);
    access(0, 3'b010, 32'h500, 32'h0,        32'hA5A5F00F, 0, 0, 1, 32'hA5A5F00F, 0, 0, 4'b0000, 3);

    @(posedge clk); @(negedge clk);
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
